// File: rtl/key_repeat_pkg.sv
// Shared definitions for the key_repeat slice: key indices, FSM states and the
// delay-timer load width, plus the saturating interval step used by the accel build.
package key_repeat_pkg;

  localparam int DLY_MS_W = 8;

  typedef enum int {
    KEY_UP    = 0,
    KEY_DOWN  = 1,
    KEY_LEFT  = 2,
    KEY_RIGHT = 3
  } key_id_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEB  = 2'd1,
    EMIT = 2'd2,
    HOLD = 2'd3
  } kr_state_e;

  // max(cur - step, floor) without ever wrapping below zero
  function automatic logic [DLY_MS_W-1:0] sat_step(input logic [DLY_MS_W-1:0] cur,
                                                   input logic [DLY_MS_W-1:0] step,
                                                   input logic [DLY_MS_W-1:0] floor);
    logic [DLY_MS_W-1:0] diff;
    diff = (cur > step) ? cur - step : '0;
    return (diff > floor) ? diff : floor;
  endfunction

endpackage

// File: rtl/key_sync.sv
// N-bit two-flop synchronizer for the raw, clock-asynchronous button inputs.
module key_sync #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_repeat.sv
// Debounced auto-repeat front end: drives the external delay timer and offers one-hot
// moves on a valid/ready handshake. Define KEY_REPEAT_ACCEL_EN for an accelerating repeat rate.
module key_repeat
  import key_repeat_pkg::*;
#(
  parameter int N_KEYS        = 4,
  parameter int DEBOUNCE_MS   = 20,
  parameter int FIRST_MS      = 250,
  parameter int REPEAT_MS     = 100,
  parameter int ACCEL_STEP_MS = 10,
  parameter int ACCEL_MIN_MS  = 30
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_KEYS-1:0]   btn,
  output logic                dly_set,
  output logic [DLY_MS_W-1:0] dly_ms,
  input  logic                dly_free,
  output logic                move_valid,
  output logic [N_KEYS-1:0]   move_dir,
  input  logic                move_ready
);

  localparam int KW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
  localparam logic [DLY_MS_W-1:0] DEB_MS   = DLY_MS_W'(DEBOUNCE_MS);
  localparam logic [DLY_MS_W-1:0] FIRST_LD = DLY_MS_W'(FIRST_MS);
  localparam logic [DLY_MS_W-1:0] REP_MS   = DLY_MS_W'(REPEAT_MS);

  if (N_KEYS < 1 || DEBOUNCE_MS > 255 || FIRST_MS > 255 || REPEAT_MS > 255 ||
      ACCEL_STEP_MS > 255 || ACCEL_MIN_MS > 255) begin : g_bad_param
    $error("key_repeat: N_KEYS must be >= 1 and every *_MS parameter must fit in 8 bits");
  end

  kr_state_e           state, state_next;
  logic [N_KEYS-1:0]   btn_s;
  logic [KW-1:0]       key_idx, key_next, low_idx;
  logic                first_done, first_next;
  logic                guard;
  logic                any_btn, key_held;
  logic [DLY_MS_W-1:0] interval;

  key_sync #(.N(N_KEYS)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn),
    .q   (btn_s)
  );

  // Lowest pressed index wins, so scan from the top down
  always_comb begin
    low_idx = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (btn_s[i]) low_idx = KW'(i);
    end
  end

  assign any_btn  = |btn_s;
  assign key_held = btn_s[key_idx];

`ifdef KEY_REPEAT_ACCEL_EN
  localparam logic [DLY_MS_W-1:0] STEP_MS = DLY_MS_W'(ACCEL_STEP_MS);
  localparam logic [DLY_MS_W-1:0] MIN_MS  = DLY_MS_W'(ACCEL_MIN_MS);
  logic [DLY_MS_W-1:0] interval_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) interval <= REP_MS;
    else     interval <= interval_next;
  end

  // Each accepted repeat shortens the next gap; a fresh press starts over
  always_comb begin
    interval_next = interval;
    if (state == IDLE)
      interval_next = REP_MS;
    else if (state == EMIT && move_ready && first_done)
      interval_next = sat_step(interval, STEP_MS, MIN_MS);
  end
`else
  assign interval = REP_MS;
`endif

  // The timer's free flag is stale for one cycle after a load, so remember the load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      key_idx    <= '0;
      first_done <= 1'b0;
      guard      <= 1'b0;
    end else begin
      state      <= state_next;
      key_idx    <= key_next;
      first_done <= first_next;
      guard      <= dly_set;
    end
  end

  always_comb begin
    state_next = state;
    key_next   = key_idx;
    first_next = first_done;
    dly_set    = 1'b0;
    dly_ms     = '0;
    move_valid = 1'b0;
    move_dir   = '0;
    case (state)
      IDLE: begin
        first_next = 1'b0;
        if (any_btn) begin
          key_next   = low_idx;
          dly_set    = 1'b1;
          dly_ms     = DEB_MS;
          state_next = DEB;
        end
      end
      DEB, HOLD: begin
        if (!key_held)
          state_next = IDLE;
        else if (dly_free && !guard)
          state_next = EMIT;
      end
      EMIT: begin
        move_valid = 1'b1;
        move_dir   = N_KEYS'(1) << key_idx;
        if (move_ready) begin
          if (key_held) begin
            dly_set    = 1'b1;
            dly_ms     = first_done ? interval : FIRST_LD;
            first_next = 1'b1;
            state_next = HOLD;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
